// File: rtl/sram_access_arbiter_pkg.sv
// Shared constants and types for the histogram SRAM arbiter.
package sram_access_arbiter_pkg;

  // Default geometry of the SiFH histogram SRAM
  localparam int RAM_ADDR_DEF      = 10;
  localparam int PEAK_MAX_DEF      = 16;
  localparam int BIN_NUM_PER_HIS   = 64;
  localparam int PIXEL_NUM_PER_RAM = 16;
  localparam int NUM_WORDS_DEF     = BIN_NUM_PER_HIS * PIXEL_NUM_PER_RAM;

  // Arbiter states, 3-bit encoding
  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    READY   = 3'd1,
    GNT_HIS = 3'd2,
    GNT_PK  = 3'd3
  } arbState_t;

  // Requester served most recently, used to break ties
  typedef enum logic {
    OWNER_HIS = 1'b0,
    OWNER_PK  = 1'b1
  } owner_t;

endpackage

// File: rtl/sram_clear_sweep.sv
// Address sweep used to zero the SRAM: one address per cycle, ascending.
// Comes out of reset already running so the SRAM is cleared at power-up.
module sram_clear_sweep
  import sram_access_arbiter_pkg::*;
#(
  parameter int RAM_ADDR  = RAM_ADDR_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  output logic [RAM_ADDR-1:0] addr,
  output logic                busy,
  output logic                last,
  output logic                done
);

  localparam logic [RAM_ADDR-1:0] LAST_ADDR = RAM_ADDR'(NUM_WORDS - 1);

  assign last = busy && (addr == LAST_ADDR);

  // Counter advance; done pulses the cycle after the final address
  always_ff @(posedge clk) begin
    if (!res) begin
      addr <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        addr <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        if (last) begin
          addr <= '0;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Owns the histogram SRAM pins: clears it after reset or on request, then
// hands the ports to HIS or PK one at a time. Every pin is registered.
module sram_access_arbiter
  import sram_access_arbiter_pkg::*;
#(
  parameter int RAM_ADDR  = RAM_ADDR_DEF,
  parameter int CNT_W     = PEAK_MAX_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                clk,
  input  logic                res,
  input  logic                clr_start,
  input  logic                his_req,
  output logic                his_gnt,
  input  logic [RAM_ADDR-1:0] his_waddr,
  input  logic [RAM_ADDR-1:0] his_raddr,
  input  logic                his_wEnable,
  input  logic                his_rEnable,
  input  logic                his_writeFlag,
  input  logic                his_readFlag,
  input  logic [CNT_W-1:0]    his_newCounts,
  input  logic                pk_req,
  output logic                pk_gnt,
  input  logic [RAM_ADDR-1:0] pk_raddr,
  input  logic                pk_readFlag,
  output logic [RAM_ADDR-1:0] waddr,
  output logic [RAM_ADDR-1:0] raddr,
  output logic                wEnable,
  output logic                rEnable,
  output logic                writeFlag,
  output logic                readFlag,
  output logic [CNT_W-1:0]    newCounts,
  output logic                clr_busy,
  output logic                clr_done
);

  typedef struct packed {
    logic [RAM_ADDR-1:0] waddr;
    logic [RAM_ADDR-1:0] raddr;
    logic                wEnable;
    logic                rEnable;
    logic                writeFlag;
    logic                readFlag;
    logic [CNT_W-1:0]    newCounts;
  } pins_t;

  arbState_t           state, stateNext;
  owner_t              last, lastNext;
  logic                clrPend;
  pins_t               pinNext, pinReg;
  logic [RAM_ADDR-1:0] sweepAddr;
  logic                sweepBusy, sweepLast, sweepDone, sweepStart;

  // A pending clear is launched from READY and beats both requesters
  assign sweepStart = (state == READY) && clrPend;

  sram_clear_sweep #(
    .RAM_ADDR (RAM_ADDR),
    .NUM_WORDS(NUM_WORDS)
  ) uSweep (
    .clk  (clk),
    .res  (res),
    .start(sweepStart),
    .addr (sweepAddr),
    .busy (sweepBusy),
    .last (sweepLast),
    .done (sweepDone)
  );

  // Next state and pin mux; pins default to idle so an ungranted or
  // releasing requester never leaks onto the SRAM
  always_comb begin
    stateNext = state;
    lastNext  = last;
    pinNext   = '0;
    case (state)
      CLEAR: begin
        pinNext.waddr     = sweepAddr;
        pinNext.wEnable   = 1'b1;
        pinNext.writeFlag = 1'b1;
        if (sweepLast) stateNext = READY;
      end
      READY: begin
        if (clrPend)                stateNext = CLEAR;
        else if (his_req && pk_req) stateNext = (last == OWNER_PK) ? GNT_HIS : GNT_PK;
        else if (his_req)           stateNext = GNT_HIS;
        else if (pk_req)            stateNext = GNT_PK;
      end
      GNT_HIS: begin
        if (his_req) begin
          pinNext.waddr     = his_waddr;
          pinNext.raddr     = his_raddr;
          pinNext.wEnable   = his_wEnable;
          pinNext.rEnable   = his_rEnable;
          pinNext.writeFlag = his_writeFlag;
          pinNext.readFlag  = his_readFlag;
          pinNext.newCounts = his_newCounts;
        end else begin
          stateNext = READY;
          lastNext  = OWNER_HIS;
        end
      end
      GNT_PK: begin
        if (pk_req) begin
          pinNext.raddr    = pk_raddr;
          pinNext.readFlag = pk_readFlag;
        end else begin
          stateNext = READY;
          lastNext  = OWNER_PK;
        end
      end
      default: stateNext = READY;
    endcase
  end

  // State, tie-break memory, clear request latch and pin registers
  always_ff @(posedge clk) begin
    if (!res) begin
      state    <= CLEAR;
      last     <= OWNER_PK;
      clrPend  <= 1'b0;
      pinReg   <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= stateNext;
      last     <= lastNext;
      clrPend  <= (clrPend && (state != READY)) || (clr_start && (state != CLEAR));
      pinReg   <= pinNext;
      clr_busy <= sweepBusy;
      clr_done <= sweepDone;
    end
  end

  assign his_gnt   = (state == GNT_HIS);
  assign pk_gnt    = (state == GNT_PK);
  assign waddr     = pinReg.waddr;
  assign raddr     = pinReg.raddr;
  assign wEnable   = pinReg.wEnable;
  assign rEnable   = pinReg.rEnable;
  assign writeFlag = pinReg.writeFlag;
  assign readFlag  = pinReg.readFlag;
  assign newCounts = pinReg.newCounts;

endmodule
